// File: rtl/flexka_result_merging_pkg.sv
// Shared types and sizes for the Karatsuba result-merging block.
//   FSIZE          : buffer word width in bits
//   IN_BUFFER_SIZE : buffer depth in words; AW is its address width
//   SSIZE          : width of position/size operands (same as AW)
//   rm_state_e     : merge FSM states
//   rm_ctrl_t      : per-read tag carried alongside the RAM read latency
//   buffer_ram_inputs_r2w1_t : request side of the R2W1 buffer RAM port
package flexka_result_merging_pkg;

  localparam int unsigned FSIZE               = 64;
  localparam int unsigned IN_BUFFER_SIZE      = 256;
  localparam int unsigned AW                  = $clog2(IN_BUFFER_SIZE);
  localparam int unsigned SSIZE               = AW;
  localparam int unsigned BUFFER_READ_LATENCY = 2;

  typedef enum logic [1:0] {
    StIdle,
    StReadAdd,
    StReadProp,
    StDrain
  } rm_state_e;

  typedef struct packed {
    logic valid;
    logic is_add;
  } rm_ctrl_t;

  typedef struct packed {
    logic [AW-1:0]    raddr0;
    logic [AW-1:0]    raddr1;
    logic [AW-1:0]    waddr;
    logic [FSIZE-1:0] wdata;
    logic             wren;
  } buffer_ram_inputs_r2w1_t;

endpackage

// File: rtl/flexka_result_merging_if.sv
// Bus bundle between the recursion controller, the result-merging block and
// the buffer RAM.
//   RM_start / operands  : controller -> merger, sampled on the start pulse
//   RM_done / RM_overflow: merger -> controller, level status
//   ram_inputs(_read_valid): merger -> RAM request (two reads, one write)
//   ram_outputs_rdata0/1 : RAM -> merger read data
// Modport slave is the merger; master is the controller/RAM side.
interface flexka_result_merging_if;
  import flexka_result_merging_pkg::*;

  logic                    RM_start;
  logic [SSIZE-1:0]        res_pos;
  logic [SSIZE-1:0]        res_size;
  logic [SSIZE-1:0]        msize;
  logic [SSIZE-1:0]        z1_pos;
  logic [SSIZE-1:0]        z1_size;
  logic                    RM_done;
  logic                    RM_overflow;
  logic                    ram_inputs_read_valid;
  buffer_ram_inputs_r2w1_t ram_inputs;
  logic [FSIZE-1:0]        ram_outputs_rdata0;
  logic [FSIZE-1:0]        ram_outputs_rdata1;

  modport slave (
    input  RM_start, res_pos, res_size, msize, z1_pos, z1_size,
    input  ram_outputs_rdata0, ram_outputs_rdata1,
    output RM_done, RM_overflow, ram_inputs_read_valid, ram_inputs
  );

  modport master (
    output RM_start, res_pos, res_size, msize, z1_pos, z1_size,
    output ram_outputs_rdata0, ram_outputs_rdata1,
    input  RM_done, RM_overflow, ram_inputs_read_valid, ram_inputs
  );

endinterface

// File: rtl/flexka_result_merging_fifo_buffer.sv
// Fixed-latency delay line (FifoBuffer): din reappears on dout exactly CYCLES
// clocks later. Used to carry read tags in step with the RAM read latency.
//   clk  : clock
//   rstn : asynchronous active-low clear of every stage
//   din  : word entering the line
//   dout : word leaving the line
module flexka_result_merging_fifo_buffer #(
  parameter int unsigned DATA_SIZE = 2,
  parameter int unsigned CYCLES    = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] dout
);

  logic [DATA_SIZE-1:0] stage_q [CYCLES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(CYCLES); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(CYCLES); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[CYCLES-1];

endmodule

// File: rtl/flexka_result_merging.sv
// Adds the middle Karatsuba term Z1 into the result region at word offset
// msize (res[res_pos+msize+i] += z1[i]) and ripples the carry upward until it
// dies or the region ends.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of flexka_result_merging_if (start/operands,
//              done/overflow status, R2W1 buffer RAM port)
// Reads are issued one pair per cycle; a tag FIFO matches each returning word
// with its kind (add or carry-propagate) so the adder stage stays stateless
// apart from the carry.
module flexka_result_merging
  import flexka_result_merging_pkg::*;
#(
  parameter int unsigned RD_LAT = BUFFER_READ_LATENCY
) (
  input logic                    clk,
  input logic                    rst,
  flexka_result_merging_if.slave bus
);

  localparam int unsigned CntW = $clog2(RD_LAT + 2);

  rm_state_e        state_q, state_d;
  logic [AW-1:0]    raddr0_q, raddr1_q, res_end_q, add_left_q;
  logic [AW-1:0]    waddr_q, waddr_next_q;
  logic [FSIZE-1:0] wdata_q;
  logic             wren_q, carry_q, stop_q, done_q, overflow_q;
  logic [CntW-1:0]  inflight_q;

  logic             issue, issue_add, drain_done, fifo_rstn, ret_live;
  rm_ctrl_t         tag_in, tag_out;
  logic [FSIZE-1:0] addend;
  logic [FSIZE:0]   sum;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next state; a start pulse restarts from any state
  always_comb begin
    state_d = state_q;
    if (bus.RM_start) begin
      state_d = StReadAdd;
    end else begin
      case (state_q)
        StReadAdd: begin
          if (add_left_q == AW'(1)) begin
            state_d = (raddr0_q == res_end_q) ? StDrain : StReadProp;
          end
        end
        StReadProp: if (stop_q || raddr0_q == res_end_q) state_d = StDrain;
        StDrain:    if (inflight_q == '0) state_d = StIdle;
        default:    state_d = state_q;
      endcase
    end
  end

  // FSM outputs: read issue and its tag
  always_comb begin
    issue      = 1'b0;
    issue_add  = 1'b0;
    drain_done = 1'b0;
    if (!bus.RM_start) begin
      case (state_q)
        StReadAdd: begin
          issue     = 1'b1;
          issue_add = 1'b1;
        end
        StReadProp: issue      = !stop_q;
        StDrain:    drain_done = (inflight_q == '0);
        default:    issue      = 1'b0;
      endcase
    end
  end

  assign tag_in = '{valid: issue, is_add: issue_add};

  // Start also clears the tag line so reads from an aborted run never land
  assign fifo_rstn = !(rst | bus.RM_start);

  flexka_result_merging_fifo_buffer #(
    .DATA_SIZE(2),
    .CYCLES   (RD_LAT)
  ) u_ctrl_fifo (
    .clk (clk),
    .rstn(fifo_rstn),
    .din (tag_in),
    .dout(tag_out)
  );

  // Read pointers, counters and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr0_q   <= '0;
      raddr1_q   <= '0;
      add_left_q <= '0;
      res_end_q  <= '0;
      inflight_q <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.RM_start) begin
      raddr0_q   <= bus.res_pos + bus.msize;
      raddr1_q   <= bus.z1_pos;
      add_left_q <= bus.z1_size;
      res_end_q  <= bus.res_pos + bus.res_size - AW'(1);
      inflight_q <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (issue) raddr0_q <= raddr0_q + AW'(1);
      if (issue_add) begin
        raddr1_q   <= raddr1_q + AW'(1);
        add_left_q <= add_left_q - AW'(1);
      end
      inflight_q <= inflight_q + CntW'(issue) - CntW'(tag_out.valid);
      // The last returned word has already been registered, so carry_q is
      // the carry out of the top word written (or 0 if propagation stopped)
      if (drain_done) begin
        done_q     <= 1'b1;
        overflow_q <= carry_q;
      end
    end
  end

  // Adder stage on returned RAM words
  assign ret_live = tag_out.valid && !stop_q;
  assign addend   = tag_out.is_add ? bus.ram_outputs_rdata1 : '0;
  assign sum      = {1'b0, bus.ram_outputs_rdata0} + {1'b0, addend} + {{FSIZE{1'b0}}, carry_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wren_q       <= 1'b0;
      wdata_q      <= '0;
      waddr_q      <= '0;
      waddr_next_q <= '0;
      carry_q      <= 1'b0;
      stop_q       <= 1'b0;
    end else if (bus.RM_start) begin
      wren_q       <= 1'b0;
      waddr_next_q <= bus.res_pos + bus.msize;
      carry_q      <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      wren_q <= 1'b0;
      if (ret_live) begin
        if (!tag_out.is_add && !carry_q) begin
          // Carry died: this word and everything after it stay untouched
          stop_q <= 1'b1;
        end else begin
          wren_q       <= 1'b1;
          wdata_q      <= sum[FSIZE-1:0];
          carry_q      <= sum[FSIZE];
          waddr_q      <= waddr_next_q;
          waddr_next_q <= waddr_next_q + AW'(1);
        end
      end
    end
  end

  always_comb begin
    bus.ram_inputs = '{
      raddr0: raddr0_q,
      raddr1: raddr1_q,
      waddr:  waddr_q,
      wdata:  wdata_q,
      wren:   wren_q
    };
  end

  assign bus.ram_inputs_read_valid = issue;
  assign bus.RM_done               = done_q;
  assign bus.RM_overflow           = overflow_q;

endmodule
